rr_reg_arbiter: RTL and testbench
=================================

Name: rr_reg_arbiter

Overview:
- Round-robin arbiter that shares one W-bit storage register among N requesters.
- Grants exclusive write ownership to one requester at a time and captures the owner's data into the shared register.
- Sits between requester logic and the shared register; the register is built from asynchronously-reset flops inside this block.

Parameters:
N, 4, number of requesters (2..8)
W, 8, width of shared register and each data input
MAX_HOLD, 8, maximum consecutive grant cycles per ownership (1..255); used only with ARB_TIMEOUT_EN

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req  input  N  request per requester; held high while ownership is wanted
wr  input  N  write strobe per requester; honoured only for current owner
din  input  N*W  flattened data; requester i occupies bits [i*W +: W]
grant  output  N  one-hot ownership, registered
owner  output  clog2(N)  index of current owner; valid when busy=1
busy  output  1  high while in GRANT state
q  output  W  shared register contents
timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset (asserted at any time, including mid-grant):
  - state=IDLE, grant=0, owner=0, busy=0, q=0, timeout=0.
  - Priority pointer=0, hold count=0.
  - Takes effect immediately (async); first arbitration is on the first rising edge after reset deasserts.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req!=0, select the first requester with req=1 searching from pointer upward, wrapping modulo N.
  - Next edge: state=GRANT, grant=onehot(sel), owner=sel, busy=1, hold count=1.
  - Latency req->grant is exactly 1 cycle from idle.
  - If req==0, stay in IDLE.
- GRANT:
  - Each edge with wr[owner]=1 and req[owner]=1: q <= din[owner]. Write is visible on q the next cycle.
  - wr from non-owners is ignored.
  - req[owner]=0 at an edge: state=RELEASE, grant=0, busy=0. A write in that same cycle is NOT captured.
  - Otherwise hold count increments, saturating at 255.
- RELEASE:
  - Exactly one cycle with grant=0.
  - pointer <= (owner+1) mod N, then state=IDLE.
  - Back-to-back owners therefore see a 2-cycle gap (RELEASE + IDLE arbitration edge).
- Fairness: any continuously requesting requester is granted within N-1 other ownerships.
- Simultaneous events:
  - Release and a new req from the same requester in the same cycle: the request is ignored until IDLE. The pointer has advanced, so others get priority.
  - Reset concurrent with any event: reset wins.
- q retains its value across ownership changes; only owner writes modify it.
- grant is always one-hot or zero; it is never multi-hot.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: in GRANT, when hold count == MAX_HOLD at an edge, go to RELEASE as if req dropped.
  - timeout pulses high for the RELEASE cycle.
  - A write in the expiring cycle IS captured, since req is still high.
- Undefined: no hold limit. Ownership lasts until req[owner] drops. timeout is tied to 0 and the hold counter is still present (debug only).

Decomposition:
- Package arb_pkg:
  - state enum (IDLE, GRANT, RELEASE), 2-bit.
  - localparam function for clog2 width of owner.
  - HOLD_CNT_W=8.
- Sub-module rr_pick: purely combinational, inputs req[N] and pointer, outputs found and sel index. Instantiated once.
- The FSM, counter, pointer and q register stay in rr_reg_arbiter.

Test Plan:
1. Reset mid-grant: owner=2 with q=0x5A, assert reset between edges -> grant=0, busy=0, q=0x00 immediately, without waiting for clk.
2. Single requester: req=0001, wr=0001 and din[0]=0x3C for 3 cycles -> grant=0001 1 cycle after req, q=0x3C; req drops -> 1 RELEASE cycle, then IDLE.
3. Round-robin: req=1111 held, each owner drops req after 2 grant cycles then reasserts -> grant order 0,1,2,3,0 with a 2-cycle gap between grants.
4. Non-owner write: owner=1, wr=0101 with din[0]=0xFF, din[2]=0xEE -> q unchanged.
5. With ARB_TIMEOUT_EN and MAX_HOLD=4: req=0011 held -> owner 0 granted 4 cycles, timeout pulse, then owner 1 granted. Without the macro, owner 0 keeps grant indefinitely.
6. Pointer wrap: pointer=3, req=1001 -> requester 3 granted first, then 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
// ARB_TIMEOUT_EN (optional macro) enables the MAX_HOLD ownership limit in rr_reg_arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int HOLD_CNT_W = 8;

    // Width of an index into N requesters; never narrower than one bit.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int OW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] ptr,
    output logic          found,
    output logic [OW-1:0] sel
);

    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = OW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter granting one requester at a time write ownership of a shared W-bit register.
// Optional macro ARB_TIMEOUT_EN: revoke a grant after MAX_HOLD cycles and pulse timeout.
module rr_reg_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N-1:0]                req,
    input  logic [N-1:0]                wr,
    input  logic [N*W-1:0]              din,
    output logic [N-1:0]                grant,
    output logic [arb_pkg::owner_w(N)-1:0] owner,
    output logic                        busy,
    output logic [W-1:0]                q,
    output logic                        timeout
);

    localparam int OW = owner_w(N);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("rr_reg_arbiter: N must be in 2..8");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_reg_arbiter: MAX_HOLD must be in 1..255");
    end

    state_e                state_q, state_d;
    logic [N-1:0]          grant_q, grant_d;
    logic [OW-1:0]         owner_q, owner_d;
    logic [OW-1:0]         ptr_q, ptr_d;
    logic [HOLD_CNT_W-1:0] hold_q, hold_d;
    logic [W-1:0]          data_q, data_d;
    logic                  found;
    logic [OW-1:0]         sel;

    rr_pick #(
        .N  (N),
        .OW (OW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (found),
        .sel   (sel)
    );

`ifdef ARB_TIMEOUT_EN
    logic timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        data_d  = data_q;
`ifdef ARB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = GRANT;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    owner_d      = sel;
                    hold_d       = HOLD_CNT_W'(1);
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    // A write in the dropping cycle is deliberately discarded.
                    state_d = RELEASE;
                    grant_d = '0;
                end else begin
                    if (wr[owner_q]) begin
                        data_d = din[int'(owner_q)*W +: W];
                    end
                    if (hold_q != '1) begin
                        hold_d = hold_q + 1'b1;
                    end
`ifdef ARB_TIMEOUT_EN
                    if (hold_q == HOLD_CNT_W'(MAX_HOLD)) begin
                        state_d   = RELEASE;
                        grant_d   = '0;
                        timeout_d = 1'b1;
                    end
`endif
                end
            end
            RELEASE: begin
                // Advancing past the old owner gives everyone else priority next round.
                ptr_d   = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = (state_q == GRANT);
    assign q     = data_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed self-checking bench for rr_reg_arbiter (N=4, W=8, MAX_HOLD=4).
module tb_rr_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   wr;
    logic [N*W-1:0] din;
    logic [N-1:0]   grant;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   q;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr      (wr),
        .din     (din),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .q       (q),
        .timeout (timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        wr    = '0;
        din   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || q !== 8'h00 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state grant=%b busy=%b owner=%0d q=%h timeout=%b required 0000/0/0/00/0",
                     grant, busy, owner, q, timeout);
        end
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req grant=%b busy=%b required 0000/0", grant, busy);
        end
    endtask

    task automatic test_single();
        req = 4'b0001;
        wr  = 4'b0001;
        din[0*W +: W] = 8'h3C;
        step();
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1 || owner !== 2'd0 || q !== 8'h00) begin
            errors++;
            $display("FAIL single_grant grant=%b busy=%b owner=%0d q=%h required 0001/1/0/00", grant, busy, owner, q);
        end
        step();
        checks++;
        if (q !== 8'h3C) begin
            errors++;
            $display("FAIL single_write q=%h required 3c", q);
        end
        step();
        // drop request while still strobing a different value: must not be captured
        req = 4'b0000;
        din[0*W +: W] = 8'h77;
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || q !== 8'h3C) begin
            errors++;
            $display("FAIL single_release grant=%b busy=%b q=%h required 0000/0/3c", grant, busy, q);
        end
        wr = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || q !== 8'h3C) begin
            errors++;
            $display("FAIL single_idle grant=%b busy=%b q=%h required 0000/0/3c", grant, busy, q);
        end
    endtask

    // Pointer is 1 on entry, so requester 1 becomes owner.
    task automatic test_non_owner_write();
        req = 4'b0010;
        step();
        checks++;
        if (grant !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("FAIL nonowner_grant grant=%b owner=%0d required 0010/1", grant, owner);
        end
        wr = 4'b0101;
        din[0*W +: W] = 8'hFF;
        din[1*W +: W] = 8'h11;
        din[2*W +: W] = 8'hEE;
        step();
        step();
        checks++;
        if (q !== 8'h3C) begin
            errors++;
            $display("FAIL nonowner_ignored q=%h required 3c", q);
        end
        wr = 4'b0010;
        step();
        checks++;
        if (q !== 8'h11) begin
            errors++;
            $display("FAIL owner_write q=%h required 11", q);
        end
        wr  = 4'b0000;
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        int           k;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            k     = i % N;
            exp_g = 4'b0001 << k;
            step();
            checks++;
            if (grant !== exp_g || owner !== 2'(k) || busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant_%0d grant=%b owner=%0d required %b/%0d", i, grant, owner, exp_g, k);
            end
            step();
            checks++;
            if (grant !== exp_g) begin
                errors++;
                $display("FAIL rr_hold_%0d grant=%b required %b", i, grant, exp_g);
            end
            req[k] = 1'b0;
            step();
            checks++;
            if (grant !== 4'b0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap1_%0d grant=%b busy=%b required 0000/0", i, grant, busy);
            end
            req[k] = 1'b1;
            step();
            checks++;
            if (grant !== 4'b0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap2_%0d grant=%b busy=%b required 0000/0", i, grant, busy);
            end
        end
        req = 4'b0000;
        step();
        step();
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        wr  = 4'b0001;
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i <= MH; i++) begin
            step();
            checks++;
            if (grant !== 4'b0001 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold_%0d grant=%b timeout=%b required 0001/0", i, grant, timeout);
            end
            din[0*W +: W] = 8'hA0 + 8'(i);
        end
        step();
        checks++;
        if (grant !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b0 || q !== 8'hA4) begin
            errors++;
            $display("FAIL to_expire grant=%b timeout=%b busy=%b q=%h required 0000/1/0/a4", grant, timeout, busy, q);
        end
        step();
        checks++;
        if (timeout !== 1'b0 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL to_pulse_end timeout=%b grant=%b required 0/0000", timeout, grant);
        end
        step();
        checks++;
        if (grant !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("FAIL to_next_owner grant=%b owner=%0d required 0010/1", grant, owner);
        end
`else
        for (int i = 1; i <= 3 * MH; i++) begin
            step();
            checks++;
            if (grant !== 4'b0001 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL no_to_hold_%0d grant=%b timeout=%b required 0001/0", i, grant, timeout);
            end
        end
`endif
        req = 4'b0000;
        wr  = 4'b0000;
        step();
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0100;
        step();
        req = 4'b0000;
        step();
        step();
        req = 4'b1001;
        step();
        checks++;
        if (grant !== 4'b1000 || owner !== 2'd3) begin
            errors++;
            $display("FAIL wrap_first grant=%b owner=%0d required 1000/3", grant, owner);
        end
        req = 4'b0001;
        step();
        step();
        step();
        checks++;
        if (grant !== 4'b0001 || owner !== 2'd0) begin
            errors++;
            $display("FAIL wrap_second grant=%b owner=%0d required 0001/0", grant, owner);
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100;
        wr  = 4'b0100;
        din[2*W +: W] = 8'h5A;
        step();
        step();
        checks++;
        if (grant !== 4'b0100 || owner !== 2'd2 || q !== 8'h5A) begin
            errors++;
            $display("FAIL mid_setup grant=%b owner=%0d q=%h required 0100/2/5a", grant, owner, q);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || q !== 8'h00 || owner !== 2'd0) begin
            errors++;
            $display("FAIL mid_async_reset grant=%b busy=%b q=%h owner=%0d required 0000/0/00/0", grant, busy, q, owner);
        end
        req = '0;
        wr  = '0;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        wr    = '0;
        din   = '0;
        test_reset();
        test_single();
        test_non_owner_write();
        test_round_robin();
        test_timeout();
        test_wrap();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
